// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter with idle-high TX and a sticky tx_done flag.
// Define UART_TX_FIFO_EN to add a DEPTH-entry byte queue ahead of the shifter.
module uart_tx_buf #(
    parameter int BAUD_DIV = 2604,
    parameter int DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       busy,
    output logic       full,
    output logic       tx_done
);
    localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [9:0]  r_shift;
    logic [11:0] r_baud_cnt;
    logic [3:0]  r_bit_cnt;
    logic        r_tx_done;

    logic        w_accept;
    logic        w_have_data;
    logic [7:0]  w_load_data;
    logic        w_load;
    logic        w_bit_tick;
    logic        w_frame_end;

    if (BAUD_DIV < 1 || BAUD_DIV > 4095 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("uart_tx_buf: BAUD_DIV must be 1..4095 and DEPTH a power of two >= 2");
    end

`ifdef UART_TX_FIFO_EN
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_full;

    // full comes from the registered count, so a same-cycle pop cannot admit a write
    assign w_full      = (r_count == CNT_FULL);
    assign w_accept    = trmt && !w_full;
    assign w_have_data = (r_count != '0);
    assign w_load_data = r_mem[r_rd_ptr];
    assign full        = w_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_load)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_accept, w_load})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept)
            r_mem[r_wr_ptr] <= tx_data;
    end
`else
    assign w_accept    = trmt && (r_state == IDLE);
    assign w_have_data = w_accept;
    assign w_load_data = tx_data;
    assign full        = busy;
`endif

    assign w_bit_tick  = (r_state == SEND) && (r_baud_cnt == '0);
    // the shift that takes bit_cnt to 10 retires the stop bit
    assign w_frame_end = w_bit_tick && (r_bit_cnt == 4'd9);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_have_data) begin
                    w_load       = 1'b1;
                    w_state_next = SEND;
                end
            end
            SEND: begin
                if (w_frame_end) begin
                    if (w_have_data)
                        w_load = 1'b1;
                    else
                        w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift    <= '1;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_tx_done  <= 1'b0;
        end else begin
            if (w_load) begin
                r_shift    <= {1'b1, w_load_data, 1'b0};
                r_baud_cnt <= BAUD_LAST;
                r_bit_cnt  <= '0;
            end else if (w_bit_tick) begin
                r_shift    <= {1'b1, r_shift[9:1]};
                r_baud_cnt <= BAUD_LAST;
                r_bit_cnt  <= r_bit_cnt + 4'd1;
            end else if (r_state == SEND) begin
                r_baud_cnt <= r_baud_cnt - 12'd1;
            end

            if (w_accept)
                r_tx_done <= 1'b0;
            else if (w_frame_end && !w_have_data)
                r_tx_done <= 1'b1;
        end
    end

    assign TX      = r_shift[0];
    assign busy    = (r_state == SEND);
    assign tx_done = r_tx_done;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Scoreboard bench for uart_tx_buf: stimulus queues expected bytes, a serial
// monitor decodes TX cycle by cycle and checks each frame. Works with or without UART_TX_FIFO_EN.
module tb_uart_tx_buf;
    localparam int BD = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       trmt = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       TX;
    logic       busy;
    logic       full;
    logic       tx_done;

    typedef struct {
        logic [7:0] data;
        bit         b2b;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    uart_tx_buf #(.BAUD_DIV(BD), .DEPTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .trmt    (trmt),
        .tx_data (tx_data),
        .TX      (TX),
        .busy    (busy),
        .full    (full),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void expect_byte(logic [7:0] d, bit b2b);
        exp_t e;
        e.data = d;
        e.b2b  = b2b;
        exp_q.push_back(e);
    endfunction

    // one-cycle write strobe; returns #1 after the sampling edge
    task automatic pulse(input logic [7:0] d);
        trmt    = 1'b1;
        tx_data = d;
        @(posedge clk); #1;
        trmt    = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!(tx_done && !busy) && n < 80 * BD) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_done"}, {busy, tx_done}, 2'b01);
    endtask

    // serial monitor: samples every cycle, so bit length and stability are exact
    initial begin
        int         m_cyc = 0;
        int         m_bit;
        int         m_gap = 0;
        int         m_last_gap = 0;
        bit         m_busy = 0;
        bit         m_stable = 1;
        logic       m_prev = 1'b1;
        logic [9:0] m_bits = '1;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_busy = 0;
                m_prev = 1'b1;
                m_gap  = 0;
            end else if (!m_busy) begin
                if (m_prev && !TX) begin
                    m_busy     = 1;
                    m_cyc      = 1;
                    m_bits     = '1;
                    m_bits[0]  = TX;
                    m_stable   = 1;
                    m_last_gap = m_gap;
                end else begin
                    m_gap++;
                end
                m_prev = TX;
            end else begin
                m_bit = m_cyc / BD;
                if (m_cyc % BD == 0)
                    m_bits[m_bit] = TX;
                else if (TX !== m_bits[m_bit])
                    m_stable = 0;
                m_cyc++;
                if (m_cyc == 10 * BD) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_frame: got 0x%02h want no frame", m_bits[8:1]);
                    end else begin
                        e = exp_q.pop_front();
                        $display("frame: rx 0x%02h exp 0x%02h gap %0d stable %0d", m_bits[8:1], e.data, m_last_gap, m_stable);
                        chk("frame_data", m_bits[8:1], e.data);
                        chk("frame_shape", {m_stable, m_bits[9], m_bits[0]}, 3'b110);
                        if (e.b2b)
                            chk("frame_gap", m_last_gap, 0);
                    end
                    m_busy = 0;
                    m_prev = TX;
                    m_gap  = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] lb [4];
`ifdef UART_TX_FIFO_EN
        int lat0 = 1;
`else
        int lat0 = 0;
`endif
        lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h5A; lb[3] = 8'hC3;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", TX, 1);
        chk("rst_busy", busy, 0);
        chk("rst_full", full, 0);
        chk("rst_done", tx_done, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // lone 0xA5 with exact start and end timing
        expect_byte(8'hA5, 0);
        pulse(8'hA5);
        chk("a5_done_clr", tx_done, 0);
        if (lat0 == 1) begin
            chk("a5_tx_wait", TX, 1);
            @(posedge clk); #1;
        end
        chk("a5_start", TX, 0);
        chk("a5_busy", busy, 1);
        repeat (10 * BD - 1) @(posedge clk);
        #1;
        chk("a5_end_early", {busy, tx_done}, 2'b10);
        @(posedge clk); #1;
        chk("a5_end", {busy, tx_done}, 2'b01);
        repeat (BD) @(posedge clk);
        #1;
        chk("a5_idle_tx", TX, 1);

        foreach (lb[i]) begin
            expect_byte(lb[i], 0);
            pulse(lb[i]);
            chk("lb_done_clr", tx_done, 0);
            wait_done($sformatf("lb%0d", i));
        end

`ifdef UART_TX_FIFO_EN
        // six held writes: five accepted, sixth sees full
        for (int i = 0; i < 6; i++) begin
            trmt    = 1'b1;
            tx_data = 8'(i + 1);
            chk($sformatf("hold_full%0d", i), full, (i == 5) ? 1 : 0);
            if (i < 5)
                expect_byte(8'(i + 1), (i != 0));
            @(posedge clk); #1;
        end
        trmt = 1'b0;
        wait_done("hold");
        chk("done_after_last", exp_q.size(), 0);

        // write while full on the same edge as a frame-boundary pop
        for (int i = 0; i < 5; i++) begin
            trmt    = 1'b1;
            tx_data = 8'(8'h10 + i);
            expect_byte(8'(8'h10 + i), (i != 0));
            @(posedge clk); #1;
        end
        trmt = 1'b0;
        repeat (10 * BD - 4) @(posedge clk);
        #1;
        trmt    = 1'b1;
        tx_data = 8'h99;
        chk("pop_full_before", full, 1);
        @(posedge clk); #1;
        trmt = 1'b0;
        chk("pop_full_after", full, 0);
        chk("pop_busy", busy, 1);
        wait_done("pop");
`else
        // write during a frame is ignored
        expect_byte(8'h11, 0);
        pulse(8'h11);
        repeat (3 * BD) @(posedge clk);
        #1;
        chk("mid_full", full, 1);
        pulse(8'h22);
        chk("mid_rej_done", tx_done, 0);
        wait_done("d11");
        expect_byte(8'h22, 0);
        pulse(8'h22);
        wait_done("d22");
`endif

        // reset mid-frame with data pending
`ifdef UART_TX_FIFO_EN
        for (int i = 0; i < 5; i++) begin
            trmt    = 1'b1;
            tx_data = 8'(8'h77 + i);
            expect_byte(8'(8'h77 + i), (i != 0));
            @(posedge clk); #1;
        end
        trmt = 1'b0;
`else
        expect_byte(8'h77, 0);
        pulse(8'h77);
`endif
        repeat (5 * BD) @(posedge clk);
        #1;
        chk("pre_rst_full", full, 1);
        rst = 1'b1;
        #1;
        chk("arst_tx", TX, 1);
        chk("arst_busy", busy, 0);
        chk("arst_full", full, 0);
        chk("arst_done", tx_done, 0);
        exp_q.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        expect_byte(8'h3C, 0);
        pulse(8'h3C);
        wait_done("post_rst");

        repeat (4 * BD) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        chk("final_tx", TX, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
